// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the PC fetch controller.
//   state_e   : controller state (BOOT, RUN, MEMW, PEND)
//   src_t     : redirect source priority code; a numerically larger code
//               means a higher priority, so sources compare with '>'
//   TRAP_VEC_DEFAULT : default trap handler address
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        MEMW = 2'd2,
        PEND = 2'd3
    } state_e;

    typedef logic [1:0] src_t;

    localparam src_t SRC_NONE = 2'd0;
    localparam src_t SRC_JMP  = 2'd1;
    localparam src_t SRC_BR   = 2'd2;
    localparam src_t SRC_TRAP = 2'd3;

    localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0010;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Bus between the fetch controller and the rest of the pipeline.
//   Requests   : IMEM_ready, HZ_stall, trap_req, br_taken_ex/br_target_ex,
//                jmp_id/jmp_target_id
//   PC control : PC_stall, PC_next_sel, PC_jump_branch
//   Pipeline   : IMEM_req, flush_if_id, flush_id_ex
//   Debug      : redir_pend, state_dbg
// Handshake: a fetch completes in a cycle where IMEM_req and IMEM_ready are
// both high; IMEM_ready low holds the PC. Redirect requests are level
// qualifiers sampled every cycle; PC_next_sel is a single-cycle command to
// the PC block and is only meaningful while PC_stall is low.
// Modports: slave = the controller, master = the surrounding pipeline.
interface pc_fetch_ctrl_if
    import pc_ctrl_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            IMEM_ready;
    logic            HZ_stall;
    logic            trap_req;
    logic            br_taken_ex;
    logic [XLEN-1:0] br_target_ex;
    logic            jmp_id;
    logic [XLEN-1:0] jmp_target_id;
    logic            PC_stall;
    logic            PC_next_sel;
    logic [XLEN-1:0] PC_jump_branch;
    logic            IMEM_req;
    logic            flush_if_id;
    logic            flush_id_ex;
    logic            redir_pend;
    state_e          state_dbg;

    modport slave (
        input  IMEM_ready, HZ_stall, trap_req, br_taken_ex, br_target_ex,
               jmp_id, jmp_target_id,
        output PC_stall, PC_next_sel, PC_jump_branch, IMEM_req,
               flush_if_id, flush_id_ex, redir_pend, state_dbg
    );

    modport master (
        output IMEM_ready, HZ_stall, trap_req, br_taken_ex, br_target_ex,
               jmp_id, jmp_target_id,
        input  PC_stall, PC_next_sel, PC_jump_branch, IMEM_req,
               flush_if_id, flush_id_ex, redir_pend, state_dbg
    );
endinterface

// File: rtl/pc_redirect_arb.sv
// Combinational redirect priority picker: trap > EX branch > ID jump.
//   trap_i              : trap request (target is the fixed TRAP_VEC)
//   br_i, br_tgt_i      : taken branch and its target
//   jmp_i, jmp_tgt_i    : jump and its target
//   vld_o, src_o, tgt_o : winning request, its priority code, its target
// tgt_o is zero when nothing is requested.
module pc_redirect_arb
    import pc_ctrl_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(TRAP_VEC_DEFAULT)
) (
    input  logic            trap_i,
    input  logic            br_i,
    input  logic [XLEN-1:0] br_tgt_i,
    input  logic            jmp_i,
    input  logic [XLEN-1:0] jmp_tgt_i,
    output logic            vld_o,
    output src_t            src_o,
    output logic [XLEN-1:0] tgt_o
);
    always_comb begin
        src_o = SRC_NONE;
        tgt_o = '0;
        if (trap_i) begin
            src_o = SRC_TRAP;
            tgt_o = TRAP_VEC;
        end else if (br_i) begin
            src_o = SRC_BR;
            tgt_o = br_tgt_i;
        end else if (jmp_i) begin
            src_o = SRC_JMP;
            tgt_o = jmp_tgt_i;
        end
    end

    assign vld_o = (src_o != SRC_NONE);
endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC sequencing controller. Combines instruction-memory handshake, hazard
// stalls and control-flow redirects into PC_stall / PC_next_sel /
// PC_jump_branch for the PC block, and raises pipeline flushes. A redirect
// that arrives while fetch is stalled is parked in a pending register and
// applied on the first unstalled cycle, so redirects are never lost.
//   CLK, RST : clock (rising edge), asynchronous active-low reset
//   bus      : pc_fetch_ctrl_if slave modport (requests in, PC control out)
module pc_fetch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(TRAP_VEC_DEFAULT),
    parameter int              BOOT_CYC = 2
) (
    input  logic             CLK,
    input  logic             RST,
    pc_fetch_ctrl_if.slave   bus
);
    localparam int BW = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYC - 1);

    state_e          state_q, state_d;
    logic [BW-1:0]   boot_cnt_q, boot_cnt_d;
    logic            pend_vld_q, pend_vld_d;
    src_t            pend_src_q, pend_src_d;
    logic [XLEN-1:0] pend_addr_q, pend_addr_d;

    logic            arb_vld;
    src_t            arb_src;
    logic [XLEN-1:0] arb_tgt;

    logic            booting;
    logic            stall_any;
    logic            next_sel;
    logic [XLEN-1:0] jump_branch;

    pc_redirect_arb #(
        .XLEN     (XLEN),
        .TRAP_VEC (TRAP_VEC)
    ) u_arb (
        .trap_i    (bus.trap_req),
        .br_i      (bus.br_taken_ex),
        .br_tgt_i  (bus.br_target_ex),
        .jmp_i     (bus.jmp_id),
        .jmp_tgt_i (bus.jmp_target_id),
        .vld_o     (arb_vld),
        .src_o     (arb_src),
        .tgt_o     (arb_tgt)
    );

    assign booting   = (state_q == BOOT);
    assign stall_any = bus.HZ_stall | ~bus.IMEM_ready | booting;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= BOOT;
            boot_cnt_q  <= '0;
            pend_vld_q  <= 1'b0;
            pend_src_q  <= SRC_NONE;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_src_q  <= pend_src_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        pend_vld_d  = pend_vld_q;
        pend_src_d  = pend_src_q;
        pend_addr_d = pend_addr_q;
        next_sel    = 1'b0;
        jump_branch = '0;

        case (state_q)
            BOOT: begin
                // Pipeline is empty during boot, so requests are ignored.
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + 1'b1;
                end
            end

            RUN, MEMW: begin
                if (arb_vld) begin
                    if (!stall_any) begin
                        next_sel    = 1'b1;
                        jump_branch = arb_tgt;
                        state_d     = RUN;
                    end else begin
                        pend_vld_d  = 1'b1;
                        pend_src_d  = arb_src;
                        pend_addr_d = arb_tgt;
                        state_d     = PEND;
                    end
                end else if (!bus.IMEM_ready) begin
                    state_d = MEMW;
                end else begin
                    state_d = RUN;
                end
            end

            PEND: begin
                if (!stall_any) begin
                    // A live request only beats the parked one if strictly
                    // higher priority; ties keep the older target.
                    next_sel    = 1'b1;
                    jump_branch = (arb_vld && (arb_src > pend_src_q)) ? arb_tgt
                                                                       : pend_addr_q;
                    pend_vld_d  = 1'b0;
                    pend_src_d  = SRC_NONE;
                    state_d     = RUN;
                end else if (arb_vld && ((arb_src > pend_src_q) || (arb_src == SRC_TRAP))) begin
                    pend_src_d  = arb_src;
                    pend_addr_d = arb_tgt;
                end
            end

            default: state_d = BOOT;
        endcase
    end

    // Flushes follow the live request even when it is only parked, so the
    // wrong-path instructions are squashed in the cycle the redirect appears.
    // A jump in ID does not squash ID/EX, which holds the jump itself.
    assign bus.flush_if_id    = arb_vld & ~booting;
    assign bus.flush_id_ex    = ((arb_src == SRC_TRAP) | (arb_src == SRC_BR)) & ~booting;

    assign bus.PC_stall       = stall_any;
    assign bus.PC_next_sel    = next_sel;
    assign bus.PC_jump_branch = jump_branch;
    assign bus.IMEM_req       = ~booting;
    assign bus.redir_pend     = pend_vld_q;
    assign bus.state_dbg      = state_q;
endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Sequencing controller for the PC register block. It generates PC_stall, PC_next_sel and PC_jump_branch from three sources: instruction-memory handshake, hazard stalls, and control-flow redirect requests (trap, EX-stage branch, ID-stage jump). It also raises pipeline flushes. It holds any redirect that arrives while fetch is stalled, so no redirect is ever lost.

Parameters:
XLEN, 32, address/data width
TRAP_VEC, 32'h0000_0010, fixed trap handler address
BOOT_CYC, 2, cycles PC held stalled after reset release (>=1)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-low reset
IMEM_ready  in  1  instruction memory accepts/returns the fetch this cycle
HZ_stall  in  1  load-use stall from hazard unit
trap_req  in  1  trap/exception request (one-cycle pulse)
br_taken_ex  in  1  branch resolved taken in EX
br_target_ex  in  XLEN  branch target
jmp_id  in  1  JAL/JALR decoded in ID
jmp_target_id  in  XLEN  jump target
PC_stall  out  1  hold PC (to PC block)
PC_next_sel  out  1  load PC_jump_branch (to PC block)
PC_jump_branch  out  XLEN  redirect address (to PC block)
IMEM_req  out  1  fetch request
flush_if_id  out  1  squash IF/ID register
flush_id_ex  out  1  squash ID/EX register
redir_pend  out  1  redirect latched, not yet applied (debug)

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous and active-low.
- Reset values: state=BOOT, boot counter=0, pending valid=0, pending addr=0. PC_stall=1, PC_next_sel=0, PC_jump_branch=0, IMEM_req=0, flushes=0, redir_pend=0.
- States:
  - BOOT: count BOOT_CYC cycles, then go to RUN.
  - RUN: normal fetch.
  - MEMW: waiting on IMEM_ready.
  - PEND: redirect held while stalled.
- Redirect priority (combinational): trap_req > br_taken_ex > jmp_id.
  - Selected target: TRAP_VEC, br_target_ex or jmp_target_id.
- Effective stall: stall_any = HZ_stall | ~IMEM_ready | (state==BOOT).
- PC_stall = stall_any. IMEM_req = 1 in every state except BOOT.
- Redirect, not stalled, no pending (RUN):
  - Same cycle: PC_next_sel=1, PC_jump_branch=target.
  - PC updates at the next edge (1-cycle latency).
  - flush_if_id=1 for all sources.
  - flush_id_ex=1 for trap and branch only; a jump in ID does not squash itself.
- Redirect while stalled:
  - Latch target into pending; go to PEND. PC_next_sel=0.
  - Flushes are still asserted that cycle, so wrong-path instructions are squashed immediately.
- PEND:
  - A new request of higher priority than the pending source overwrites it. Equal or lower priority is ignored. A trap always overwrites.
  - On the first cycle with stall_any=0: PC_next_sel=1, PC_jump_branch=pending addr; clear pending; go to RUN.
  - A live request arriving in that same cycle wins only if it has strictly higher priority; otherwise the pending address is applied.
- MEMW:
  - Entered from RUN when IMEM_ready=0 and no redirect is present.
  - Exits to RUN on IMEM_ready=1.
  - A redirect arriving in MEMW goes to PEND.
- HZ_stall with no redirect: stay in RUN, PC_stall=1, no flush.
- Idle outputs: PC_jump_branch=0 whenever PC_next_sel=0 (no X, no stale value).
- Targets: passed unmodified, no alignment check. Bits [1:0] are forwarded as given.
- Reset mid-operation: immediate return to BOOT; pending is discarded.

Decomposition:
- Package pc_ctrl_pkg holds:
  - the state enum (BOOT, RUN, MEMW, PEND);
  - the source priority codes (SRC_NONE=0, SRC_JMP=1, SRC_BR=2, SRC_TRAP=3);
  - the default TRAP_VEC.
- Sub-module pc_redirect_arb: combinational priority picker.
  - Inputs: the three requests and their targets.
  - Outputs: valid, src code, target.
  - Reused in the PEND compare.

Test Plan:
1. Reset release, BOOT_CYC=2, IMEM_ready=1, no requests -> PC_stall=1 for 2 cycles, then 0; PC advances 0,4,8; IMEM_req=1 from cycle 2.
2. In RUN, br_taken_ex=1, br_target_ex=0x100 -> same cycle PC_next_sel=1, PC_jump_branch=0x100, both flushes=1; next cycle PC=0x100.
3. IMEM_ready=0 for 3 cycles, with jmp_id=1, target 0x40, in the 1st -> flush_if_id=1 only in that cycle; redir_pend=1; PC held; first ready cycle PC_next_sel=1 with 0x40; PC=0x40 next.
4. Pending jmp 0x40, then trap_req during the stall -> pending becomes TRAP_VEC (0x10); on release PC=0x10; flush_id_ex=1 on the trap cycle.
5. Simultaneous trap_req, br_taken_ex (0x200) and jmp_id (0x300), unstalled -> PC_jump_branch=0x10, single PC_next_sel pulse.
6. RST low while in PEND -> all outputs at reset values asynchronously; after release, no redirect is applied and PC restarts at 0.
